// File: rtl/soc_wb2bb_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | soc_wb2bb_bridge: Wishbone classic slave to blackbone master stage.  |
// | SOC_WB2BB_RMW_EN: build read-modify-write support for partial writes.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module soc_wb2bb_bridge #(
  parameter  int DATA_WIDTH   = 32,
  parameter  int ADDR_WIDTH   = 32,
  parameter  int READ_LATENCY = 1,
  localparam int SEL_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic [SEL_WIDTH-1:0]  wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic [ADDR_WIDTH-1:0] bb_addr_o,
  output logic [DATA_WIDTH-1:0] bb_din_o,
  output logic                  bb_en_o,
  output logic                  bb_we_o,
  input  logic [DATA_WIDTH-1:0] bb_dout_i
);

  localparam logic [2:0] CNT_LOAD = 3'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_REQ  = 3'd3,
    S_ACK     = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
  logic                  en_q, en_d;
  logic                  we_q, we_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;

  logic sel_full;
  logic sel_none;

  assign sel_full = &wb_sel_i;
  assign sel_none = ~|wb_sel_i;

`ifdef SOC_WB2BB_RMW_EN
  logic                  rmw_q, rmw_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [DATA_WIDTH-1:0] merge;

  // Selected bytes come from the Wishbone write, the rest from the word just read.
  always_comb begin
    merge = '0;
    for (int b = 0; b < SEL_WIDTH; b++) begin
      merge[8*b +: 8] = sel_q[b] ? dat_q[8*b +: 8] : bb_dout_i[8*b +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rmw_q <= 1'b0;
      dat_q <= '0;
      sel_q <= '0;
    end else begin
      rmw_q <= rmw_d;
      dat_q <= dat_d;
      sel_q <= sel_d;
    end
  end
`endif

  // Outputs are computed for the state being entered so every one is a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rdat_d  = rdat_q;
    en_d    = 1'b0;
    we_d    = 1'b0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
`ifdef SOC_WB2BB_RMW_EN
    rmw_d   = rmw_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
`ifdef SOC_WB2BB_RMW_EN
          rmw_d = wb_we_i && !sel_full && !sel_none;
          dat_d = wb_dat_i;
          sel_d = wb_sel_i;
`endif
          if (!wb_we_i) begin
            state_d = S_RD_REQ;
            en_d    = 1'b1;
            addr_d  = wb_adr_i;
          end else if (sel_full) begin
            state_d = S_WR_REQ;
            en_d    = 1'b1;
            we_d    = 1'b1;
            addr_d  = wb_adr_i;
            din_d   = wb_dat_i;
          end else if (sel_none) begin
            state_d = S_ACK;
            ack_d   = 1'b1;
            rdat_d  = '0;
          end else begin
`ifdef SOC_WB2BB_RMW_EN
            state_d = S_RD_REQ;
            en_d    = 1'b1;
            addr_d  = wb_adr_i;
`else
            state_d = S_ACK;
            err_d   = 1'b1;
            rdat_d  = '0;
`endif
          end
        end
      end
      S_RD_REQ: begin
        if (!wb_cyc_i) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = S_IDLE;
        end else if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
`ifdef SOC_WB2BB_RMW_EN
          if (rmw_q) begin
            state_d = S_WR_REQ;
            en_d    = 1'b1;
            we_d    = 1'b1;
            din_d   = merge;
          end else begin
            state_d = S_ACK;
            ack_d   = 1'b1;
            rdat_d  = bb_dout_i;
          end
`else
          state_d = S_ACK;
          ack_d   = 1'b1;
          rdat_d  = bb_dout_i;
`endif
        end
      end
      S_WR_REQ: begin
        // The write itself is already on the bus; only the ack depends on cyc.
        if (wb_cyc_i) begin
          state_d = S_ACK;
          ack_d   = 1'b1;
          rdat_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      din_q   <= '0;
      rdat_q  <= '0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rdat_q  <= rdat_d;
      en_q    <= en_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign wb_dat_o  = rdat_q;
  assign wb_ack_o  = ack_q;
  assign wb_err_o  = err_q;
  assign bb_addr_o = addr_q;
  assign bb_din_o  = din_q;
  assign bb_en_o   = en_q;
  assign bb_we_o   = we_q;

endmodule
`default_nettype wire
